// File: rtl/crc_stream.sv
// Streaming CRC engine: one beat per cycle from sof to eof, with the result held on a valid/ready port.
// The result is valid the cycle after the eof beat. s_ready is low while the result is held.
module crc_stream #(
    parameter int unsigned      CRC_W  = 6,
    parameter int unsigned      DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'('h03),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter logic [CRC_W-1:0] XOROUT = '0,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_eof,
    input  logic [CRC_W-1:0]  s_exp,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc,
    output logic              m_ok,
    output logic [15:0]       m_len,
    output logic              drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [15:0]        len_q, len_d;
    logic [CRC_W-1:0]   m_crc_q, m_crc_d;
    logic               m_ok_q, m_ok_d;
    logic [15:0]        m_len_q, m_len_d;
    logic               drop_q, drop_d;

    logic               accept;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   result;
    logic [15:0]        len_next;

    // All DATA_W bit steps of one beat unrolled into a single cycle.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        int               idx;
        r = c;
        for (int i = 0; i < int'(DATA_W); i++) begin
            idx = REFIN ? i : int'(DATA_W) - 1 - i;
            fb  = r[CRC_W-1] ^ d[idx];
            r   = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        r = c;
        if (REFOUT) begin
            for (int i = 0; i < int'(CRC_W); i++) begin
                r[i] = c[int'(CRC_W) - 1 - i];
            end
        end
        return r ^ XOROUT;
    endfunction

    assign accept   = s_valid && s_ready;
    assign crc_next = crc_step(s_sof ? INIT : crc_q, s_data);
    assign result   = finalize(crc_next);
    assign len_next = s_sof ? 16'd1 : ((len_q == 16'hFFFF) ? len_q : len_q + 16'd1);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        m_crc_d = m_crc_q;
        m_ok_d  = m_ok_q;
        m_len_d = m_len_q;
        drop_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (state_q == ST_IDLE && !s_sof) begin
                        drop_d = 1'b1;
                    end else begin
                        // A sof arriving mid-frame abandons the open frame and restarts on this beat.
                        drop_d  = (state_q == ST_RUN) && s_sof;
                        crc_d   = crc_next;
                        len_d   = len_next;
                        state_d = ST_RUN;
                        if (s_eof) begin
                            m_crc_d = result;
                            m_ok_d  = (result == s_exp);
                            m_len_d = len_next;
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    crc_d   = INIT;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                crc_d   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            len_q   <= '0;
            m_crc_q <= '0;
            m_ok_q  <= 1'b0;
            m_len_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            m_crc_q <= m_crc_d;
            m_ok_q  <= m_ok_d;
            m_len_q <= m_len_d;
            drop_q  <= drop_d;
        end
    end

    assign s_ready = (state_q != ST_HOLD);
    assign m_valid = (state_q == ST_HOLD);
    assign m_crc   = m_crc_q;
    assign m_ok    = m_ok_q;
    assign m_len   = m_len_q;
    assign drop    = drop_q;

endmodule
